// File: rtl/reg_bank_ops.sv
// Register bank with two combinational read ports and a clocked
// load/inc/dec write port, initialised by a clear sweep.
module reg_bank_ops #(
  parameter int BIT_ADDR = 4,
  parameter int BIT_DATO = 3,
  parameter int SATURATE = 0,
  parameter logic [BIT_DATO-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIT_ADDR-1:0] addrR0,
  input  logic [BIT_ADDR-1:0] addrR1,
  output logic [BIT_DATO-1:0] datOutR0,
  output logic [BIT_DATO-1:0] datOutR1,
  input  logic [BIT_ADDR-1:0] addrW,
  input  logic [BIT_DATO-1:0] datW,
  input  logic [1:0]          op,
  input  logic                wr_req,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_ack,
  output logic                ovf
);

  localparam int NREG = 2**BIT_ADDR;
  localparam logic [BIT_ADDR-1:0] LAST = {BIT_ADDR{1'b1}};
  localparam logic [BIT_DATO-1:0] DMAX = {BIT_DATO{1'b1}};

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_DEC = 2'b11;

  logic [BIT_DATO-1:0] r_breg [NREG];
  logic [0:0]          r_state;
  logic [BIT_ADDR-1:0] r_sweep_addr;
  logic                r_busy;
  logic                r_wr_ack;
  logic                r_ovf;
  logic                r_wr_req_q;

  logic                w_edge;
  logic                w_idle;
  logic                w_we;
  logic                w_sweep_we;
  logic                w_lim;
  logic                w_upd;
  logic [BIT_DATO-1:0] w_cur;
  logic [BIT_DATO-1:0] w_nxt;

  assign datOutR0 = r_breg[addrR0];
  assign datOutR1 = r_breg[addrR1];
  assign busy     = r_busy;
  assign wr_ack   = r_wr_ack;
  assign ovf      = r_ovf;

  assign w_idle     = (r_state == S_IDLE);
  assign w_sweep_we = (r_state == S_CLEAR);
  assign w_edge     = wr_req & ~r_wr_req_q;
  // a clear request in the same cycle pre-empts the write
  assign w_we       = w_idle & ~clr_req & w_edge;
  assign w_cur      = r_breg[addrW];

  always_comb begin
    w_nxt = w_cur;
    w_lim = 1'b0;
    w_upd = 1'b0;
    unique case (op)
      OP_NOP: begin
        w_upd = 1'b0;
      end
      OP_LD: begin
        w_nxt = datW;
        w_upd = 1'b1;
      end
      OP_INC: begin
        w_upd = 1'b1;
        if (w_cur == DMAX) begin
          w_lim = 1'b1;
          w_nxt = (SATURATE != 0) ? DMAX : '0;
        end else begin
          w_nxt = w_cur + 1'b1;
        end
      end
      OP_DEC: begin
        w_upd = 1'b1;
        if (w_cur == '0) begin
          w_lim = 1'b1;
          w_nxt = (SATURATE != 0) ? '0 : DMAX;
        end else begin
          w_nxt = w_cur - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_CLEAR;
      r_sweep_addr <= '0;
      r_busy       <= 1'b1;
      r_wr_ack     <= 1'b0;
      r_ovf        <= 1'b0;
      r_wr_req_q   <= 1'b0;
    end else begin
      r_wr_req_q <= wr_req;
      r_wr_ack   <= w_we;
      r_ovf      <= w_we & w_lim;
      unique case (r_state)
        S_CLEAR: begin
          r_sweep_addr <= r_sweep_addr + 1'b1;
          if (r_sweep_addr == LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clr_req) begin
            r_state      <= S_CLEAR;
            r_sweep_addr <= '0;
            r_busy       <= 1'b1;
          end
        end
      endcase
    end
  end

  // storage is deliberately unreset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (w_sweep_we) begin
      r_breg[r_sweep_addr] <= INIT_VAL;
    end else if (w_we && w_upd) begin
      r_breg[addrW] <= w_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bank_ops.sv
// Bench for reg_bank_ops: wrap and saturate instances share stimulus
// and are checked against tables, sequences and an array model.
module tb_reg_bank_ops;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] addrR0 = '0;
  logic [3:0] addrR1 = '0;
  logic [3:0] addrW = '0;
  logic [2:0] datW = '0;
  logic [1:0] op = '0;
  logic       wr_req = 1'b0;
  logic       clr_req = 1'b0;

  logic [2:0] r0_w, r1_w, r0_s, r1_s;
  logic       busy_w, ack_w, ovf_w;
  logic       busy_s, ack_s, ovf_s;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [2:0] dat;
    logic [2:0] e_w;
    logic [2:0] e_s;
    logic       o_w;
    logic       o_s;
  } vec_t;

  vec_t tbl [12];
  int   mdl [2][16];

  always #5 clk = ~clk;

  reg_bank_ops #(
    .BIT_ADDR(4), .BIT_DATO(3), .SATURATE(0), .INIT_VAL(3'd0)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .addrR0(addrR0), .addrR1(addrR1),
    .datOutR0(r0_w), .datOutR1(r1_w),
    .addrW(addrW), .datW(datW), .op(op),
    .wr_req(wr_req), .clr_req(clr_req),
    .busy(busy_w), .wr_ack(ack_w), .ovf(ovf_w)
  );

  reg_bank_ops #(
    .BIT_ADDR(4), .BIT_DATO(3), .SATURATE(1), .INIT_VAL(3'd0)
  ) u_sat (
    .clk(clk), .rst(rst),
    .addrR0(addrR0), .addrR1(addrR1),
    .datOutR0(r0_s), .datOutR1(r1_s),
    .addrW(addrW), .datW(datW), .op(op),
    .wr_req(wr_req), .clr_req(clr_req),
    .busy(busy_s), .wr_ack(ack_s), .ovf(ovf_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy_w && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wr(input logic [1:0] o, input logic [3:0] a,
                    input logic [2:0] d,
                    output logic aw, output logic as,
                    output logic ow, output logic os);
    op = o;
    addrW = a;
    datW = d;
    wr_req = 1'b1;
    tick();
    aw = ack_w;
    as = ack_s;
    ow = ovf_w;
    os = ovf_s;
    wr_req = 1'b0;
    tick();
    chk("ack_one_cycle", {31'd0, ack_w}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, acks, ra, v, t, nv, ov;
    logic aw, as, ow, os;

    tbl[0]  = '{2'd1, 4'd2, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0};
    tbl[1]  = '{2'd2, 4'd2, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1};
    tbl[2]  = '{2'd3, 4'd2, 3'd0, 3'd7, 3'd6, 1'b1, 1'b0};
    tbl[3]  = '{2'd1, 4'd4, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{2'd3, 4'd4, 3'd0, 3'd7, 3'd0, 1'b1, 1'b1};
    tbl[5]  = '{2'd1, 4'd4, 3'd3, 3'd3, 3'd3, 1'b0, 1'b0};
    tbl[6]  = '{2'd3, 4'd4, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0};
    tbl[7]  = '{2'd0, 4'd4, 3'd5, 3'd2, 3'd2, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, 4'd4, 3'd0, 3'd3, 3'd3, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 4'd2, 3'd6, 3'd6, 3'd6, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 4'd2, 3'd0, 3'd7, 3'd7, 1'b0, 1'b0};
    tbl[11] = '{2'd2, 4'd2, 3'd0, 3'd0, 3'd7, 1'b1, 1'b1};

    repeat (2) tick();
    chk("rst_busy_w", {31'd0, busy_w}, 32'd1);
    chk("rst_busy_s", {31'd0, busy_s}, 32'd1);
    chk("rst_ack", {31'd0, ack_w}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
    rst = 1'b1;
    count_busy(cnt);
    chk("init_sweep_len", cnt, 32'd16);
    chk("init_busy_s", {31'd0, busy_s}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      wr(2'd1, 4'(i), 3'd5, aw, as, ow, os);
    end
    addrR0 = 4'd9;
    #1;
    chk("preload_5", r0_w, 32'd5);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    count_busy(cnt);
    chk("clr_sweep_len", cnt, 32'd16);
    for (int i = 0; i < 16; i++) begin
      addrR0 = 4'(i);
      addrR1 = 4'(i);
      #1;
      chk("cleared_w", r0_w, 32'd0);
      chk("cleared_s", r1_s, 32'd0);
    end

    addrW = 4'd3;
    op = 2'd1;
    datW = 3'd6;
    wr_req = 1'b1;
    acks = 0;
    repeat (5) begin
      tick();
      acks += int'(ack_w);
    end
    wr_req = 1'b0;
    tick();
    acks += int'(ack_w);
    chk("held_req_acks", acks, 32'd1);
    addrR1 = 4'd3;
    #1;
    chk("held_rd_w", r1_w, 32'd6);
    chk("held_rd_s", r1_s, 32'd6);

    datW = 3'd2;
    wr_req = 1'b1;
    #1;
    chk("rd_old_in_wr_cycle", r1_w, 32'd6);
    tick();
    chk("rd_new_after_edge", r1_w, 32'd2);
    wr_req = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      wr(tbl[i].op, tbl[i].addr, tbl[i].dat, aw, as, ow, os);
      chk($sformatf("tbl%0d_ack_w", i), {31'd0, aw}, 32'd1);
      chk($sformatf("tbl%0d_ack_s", i), {31'd0, as}, 32'd1);
      chk($sformatf("tbl%0d_ovf_w", i), {31'd0, ow}, {31'd0, tbl[i].o_w});
      chk($sformatf("tbl%0d_ovf_s", i), {31'd0, os}, {31'd0, tbl[i].o_s});
      addrR0 = tbl[i].addr;
      #1;
      chk($sformatf("tbl%0d_dat_w", i), r0_w, {29'd0, tbl[i].e_w});
      chk($sformatf("tbl%0d_dat_s", i), r0_s, {29'd0, tbl[i].e_s});
    end

    addrW = 4'd1;
    op = 2'd1;
    datW = 3'd4;
    wr_req = 1'b1;
    clr_req = 1'b1;
    tick();
    chk("collide_no_ack", {31'd0, ack_w}, 32'd0);
    chk("collide_busy", {31'd0, busy_w}, 32'd1);
    wr_req = 1'b0;
    tick();
    clr_req = 1'b0;
    addrW = 4'd5;
    datW = 3'd3;
    wr_req = 1'b1;
    tick();
    acks = int'(ack_w);
    cnt = 2;
    while (busy_w && cnt < 40) begin
      tick();
      cnt++;
      acks += int'(ack_w);
    end
    chk("collide_sweep_len", cnt, 32'd16);
    repeat (2) begin
      tick();
      acks += int'(ack_w);
    end
    chk("busy_and_held_acks", acks, 32'd0);
    wr_req = 1'b0;
    tick();
    addrR0 = 4'd1;
    addrR1 = 4'd5;
    #1;
    chk("collide_cell1", r0_w, 32'd0);
    chk("dropped_cell5", r1_s, 32'd0);

    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #3;
    chk("midrst_busy_w", {31'd0, busy_w}, 32'd1);
    chk("midrst_busy_s", {31'd0, busy_s}, 32'd1);
    chk("midrst_ack", {31'd0, ack_w}, 32'd0);
    rst = 1'b1;
    count_busy(cnt);
    chk("midrst_sweep_len", cnt, 32'd16);

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++) mdl[s][i] = 0;

    for (int it = 0; it < 150; it++) begin
      logic [1:0] o;
      logic [3:0] a;
      logic [2:0] d;
      logic       eo [2];
      o = 2'($urandom_range(0, 3));
      a = 4'($urandom_range(0, 15));
      d = 3'($urandom_range(0, 7));
      for (int s = 0; s < 2; s++) begin
        v = mdl[s][a];
        nv = v;
        ov = 0;
        if (o == 2'd1) nv = int'(d);
        if (o == 2'd2) begin
          t = v + 1;
          ov = (t > 7) ? 1 : 0;
          nv = (s == 1) ? ((t > 7) ? 7 : t) : t % 8;
        end
        if (o == 2'd3) begin
          t = v - 1;
          ov = (t < 0) ? 1 : 0;
          nv = (s == 1) ? ((t < 0) ? 0 : t) : (t + 8) % 8;
        end
        mdl[s][a] = nv;
        eo[s] = (ov != 0);
      end
      wr(o, a, d, aw, as, ow, os);
      chk("rnd_ack_w", {31'd0, aw}, 32'd1);
      chk("rnd_ovf_w", {31'd0, ow}, {31'd0, eo[0]});
      chk("rnd_ovf_s", {31'd0, os}, {31'd0, eo[1]});
      ra = $urandom_range(0, 15);
      addrR0 = 4'(ra);
      addrR1 = a;
      #1;
      chk("rnd_r0_w", r0_w, mdl[0][ra]);
      chk("rnd_r0_s", r0_s, mdl[1][ra]);
      chk("rnd_r1_w", r1_w, mdl[0][a]);
      chk("rnd_r1_s", r1_s, mdl[1][a]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
